// File: rtl/router_output_allocator.sv
// Per-output-port wormhole switch allocator: round-robin head arbitration, head-to-tail lock, on/off gating.
// Optional starvation watchdog on a locked owner is built when OUTPUT_ALLOC_WDOG_EN is defined.
module router_output_allocator #(
    parameter int NUM_IN      = 5,
    parameter int SEL_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    parameter int WDOG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] i_req,
    input  logic [NUM_IN-1:0] i_head,
    input  logic [NUM_IN-1:0] i_tail,
    input  logic              i_downstream_on,
    output logic [NUM_IN-1:0] o_grant,
    output logic [SEL_W-1:0]  o_sel,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_wdog_err
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             fsm;
    logic [SEL_W-1:0]   owner;
    logic [SEL_W-1:0]   ptr;
    // Set for one cycle after a multi-flit tail so the next packet sees a bubble.
    logic               bubble;

    logic [NUM_IN-1:0]  elig;
    logic [NUM_IN-1:0]  grant;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   winner;
    logic               found;

    function automatic logic [SEL_W-1:0] nxt(input logic [SEL_W-1:0] x);
        return (int'(x) == NUM_IN - 1) ? '0 : x + 1'b1;
    endfunction

    // Round-robin search starting at ptr, wrapping modulo NUM_IN.
    always_comb begin
        int j;
        j      = 0;
        elig   = i_req & i_head;
        found  = 1'b0;
        winner = ptr;
        for (int k = 0; k < NUM_IN; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_IN) j = j - NUM_IN;
            if (!found && elig[j]) begin
                found  = 1'b1;
                winner = SEL_W'(j);
            end
        end
    end

    always_comb begin
        grant = '0;
        sel   = owner;
        if (fsm == IDLE) begin
            if (found && i_downstream_on && !bubble) begin
                grant[winner] = 1'b1;
                sel           = winner;
            end
        end else begin
            grant[owner] = i_req[owner] & i_downstream_on;
        end
    end

    assign o_grant = reset ? '0 : grant;
    assign o_sel   = reset ? '0 : sel;
    assign o_valid = |o_grant;
    assign o_busy  = (fsm == LOCKED);

`ifdef OUTPUT_ALLOC_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    logic [CNT_W-1:0] wdog_cnt;
    logic             wdog_err;
    assign o_wdog_err = wdog_err;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign o_wdog_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm    <= IDLE;
            owner  <= '0;
            ptr    <= '0;
            bubble <= 1'b0;
`ifdef OUTPUT_ALLOC_WDOG_EN
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
`endif
        end else begin
            bubble <= 1'b0;
`ifdef OUTPUT_ALLOC_WDOG_EN
            wdog_err <= 1'b0;
`endif
            case (fsm)
                IDLE: begin
`ifdef OUTPUT_ALLOC_WDOG_EN
                    wdog_cnt <= '0;
`endif
                    if (grant[winner] && found) begin
                        if (i_tail[winner]) begin
                            ptr <= nxt(winner);
                        end else begin
                            fsm   <= LOCKED;
                            owner <= winner;
                        end
                    end
                end
                LOCKED: begin
                    if (grant[owner] && i_tail[owner]) begin
                        fsm    <= IDLE;
                        ptr    <= nxt(owner);
                        bubble <= 1'b1;
                    end
`ifdef OUTPUT_ALLOC_WDOG_EN
                    if (grant[owner]) begin
                        wdog_cnt <= '0;
                    end else if (!i_req[owner] && i_downstream_on) begin
                        if (wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
                            fsm      <= IDLE;
                            ptr      <= nxt(owner);
                            wdog_err <= 1'b1;
                            wdog_cnt <= '0;
                        end else begin
                            wdog_cnt <= wdog_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_output_allocator.sv
// Directed bench for router_output_allocator (NUM_IN=5, WDOG_CYCLES=8).
module tb_router_output_allocator;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] i_req, i_head, i_tail;
    logic       i_downstream_on;
    logic [4:0] o_grant;
    logic [2:0] o_sel;
    logic       o_valid, o_busy, o_wdog_err;
    int checks = 0;
    int failures = 0;

    router_output_allocator #(.NUM_IN(5), .WDOG_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_head(i_head), .i_tail(i_tail),
        .i_downstream_on(i_downstream_on), .o_grant(o_grant), .o_sel(o_sel),
        .o_valid(o_valid), .o_busy(o_busy), .o_wdog_err(o_wdog_err)
    );

    always #5 clk = ~clk;

    // Drive inputs mid-cycle and let combinational outputs settle before checking.
    task automatic drive(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t, input logic on);
        @(negedge clk);
        i_req = r; i_head = h; i_tail = t; i_downstream_on = on;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; i_req = '0; i_head = '0; i_tail = '0; i_downstream_on = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = '1; i_head = '1; i_tail = '1; i_downstream_on = 1'b1;
        #2;
        checks++; if (o_grant !== 5'b0) begin failures++; $display("FAIL reset_grant got=%b want=00000", o_grant); end
        checks++; if (o_sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d want=0", o_sel); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        checks++; if (o_wdog_err !== 1'b0) begin failures++; $display("FAIL reset_wdog got=%b want=0", o_wdog_err); end
        @(negedge clk);
        reset = 1'b0; i_req = '0; i_head = '0; i_tail = '0;
    endtask

    task automatic test_single();
        drive(5'b00010, 5'b00000, 5'b00000, 1'b1);
        checks++; if (o_grant !== 5'b0) begin failures++; $display("FAIL nonhead_ignored got=%b want=00000", o_grant); end
        drive(5'b00100, 5'b00100, 5'b00100, 1'b1);
        checks++; if (o_grant !== 5'b00100) begin failures++; $display("FAIL single_grant got=%b want=00100", o_grant); end
        checks++; if (o_sel !== 3'd2) begin failures++; $display("FAIL single_sel got=%0d want=2", o_sel); end
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b want=1", o_valid); end
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b want=0", o_busy); end
        checks++; if (dut.ptr !== 3'd3) begin failures++; $display("FAIL single_ptr got=%0d want=3", dut.ptr); end
    endtask

    task automatic test_packet();
        do_reset();
        drive(5'b01010, 5'b01010, 5'b00000, 1'b1);
        checks++; if (o_grant !== 5'b00010) begin failures++; $display("FAIL pkt_head got=%b want=00010", o_grant); end
        drive(5'b01010, 5'b01000, 5'b00000, 1'b1);
        checks++; if (o_grant !== 5'b00010 || o_busy !== 1'b1) begin failures++; $display("FAIL pkt_body got=%b busy=%b want=00010 busy=1", o_grant, o_busy); end
        drive(5'b01010, 5'b01000, 5'b00010, 1'b1);
        checks++; if (o_grant !== 5'b00010) begin failures++; $display("FAIL pkt_tail got=%b want=00010", o_grant); end
        drive(5'b01000, 5'b01000, 5'b00000, 1'b1);
        checks++; if (o_grant !== 5'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL pkt_bubble got=%b busy=%b want=00000 busy=0", o_grant, o_busy); end
        checks++; if (dut.ptr !== 3'd2) begin failures++; $display("FAIL pkt_ptr got=%0d want=2", dut.ptr); end
        drive(5'b01000, 5'b01000, 5'b01000, 1'b1);
        checks++; if (o_grant !== 5'b01000 || o_sel !== 3'd3) begin failures++; $display("FAIL pkt_next got=%b sel=%0d want=01000 sel=3", o_grant, o_sel); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_g [6];
        exp_g = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
            checks++; if (o_grant !== exp_g[c]) begin failures++; $display("FAIL rr_cycle%0d got=%b want=%b", c, o_grant, exp_g[c]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(5'b10000, 5'b10000, 5'b00000, 1'b1);
        checks++; if (o_grant !== 5'b10000) begin failures++; $display("FAIL bp_head got=%b want=10000", o_grant); end
        for (int c = 0; c < 10; c++) begin
            drive(5'b10000, 5'b00000, 5'b00000, 1'b0);
            checks++; if (o_grant !== 5'b0 || o_busy !== 1'b1 || o_wdog_err !== 1'b0) begin
                failures++; $display("FAIL bp_off%0d got=%b busy=%b wdog=%b want=00000 busy=1 wdog=0", c, o_grant, o_busy, o_wdog_err);
            end
        end
        drive(5'b10000, 5'b00000, 5'b00000, 1'b1);
        checks++; if (o_grant !== 5'b10000 || o_sel !== 3'd4) begin failures++; $display("FAIL bp_resume got=%b sel=%0d want=10000 sel=4", o_grant, o_sel); end
        drive(5'b10000, 5'b00000, 5'b10000, 1'b1);
        checks++; if (o_grant !== 5'b10000) begin failures++; $display("FAIL bp_tail got=%b want=10000", o_grant); end
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        checks++; if (o_busy !== 1'b0 || dut.ptr !== 3'd0) begin failures++; $display("FAIL bp_release busy=%b ptr=%0d want busy=0 ptr=0", o_busy, dut.ptr); end
    endtask

`ifdef OUTPUT_ALLOC_WDOG_EN
    task automatic test_wdog();
        int pulses;
        pulses = 0;
        do_reset();
        drive(5'b00001, 5'b00001, 5'b00000, 1'b1);
        checks++; if (o_grant !== 5'b00001) begin failures++; $display("FAIL wd_head got=%b want=00001", o_grant); end
        for (int c = 0; c < 8; c++) begin
            drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
            if (o_wdog_err) pulses++;
            checks++; if (o_grant !== 5'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL wd_wait%0d got=%b busy=%b want=00000 busy=1", c, o_grant, o_busy); end
        end
        drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
        if (o_wdog_err) pulses++;
        checks++; if (o_wdog_err !== 1'b1) begin failures++; $display("FAIL wd_pulse got=%b want=1", o_wdog_err); end
        checks++; if (o_grant !== 5'b00100) begin failures++; $display("FAIL wd_next got=%b want=00100", o_grant); end
        checks++; if (dut.ptr !== 3'd1) begin failures++; $display("FAIL wd_ptr got=%0d want=1", dut.ptr); end
        drive(5'b00100, 5'b00000, 5'b00100, 1'b1);
        if (o_wdog_err) pulses++;
        checks++; if (pulses !== 1) begin failures++; $display("FAIL wd_pulse_count got=%0d want=1", pulses); end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        drive(5'b01000, 5'b01000, 5'b00000, 1'b1);
        checks++; if (o_grant !== 5'b01000) begin failures++; $display("FAIL ar_head got=%b want=01000", o_grant); end
        drive(5'b01000, 5'b00000, 5'b00000, 1'b1);
        checks++; if (o_busy !== 1'b1 || o_grant !== 5'b01000) begin failures++; $display("FAIL ar_body got=%b busy=%b want=01000 busy=1", o_grant, o_busy); end
        #1 reset = 1'b1;
        #1;
        checks++; if (o_busy !== 1'b0 || o_grant !== 5'b0) begin failures++; $display("FAIL ar_drop got=%b busy=%b want=00000 busy=0", o_grant, o_busy); end
        @(negedge clk);
        reset = 1'b0; i_req = '0; i_head = '0; i_tail = '0;
        #1;
        checks++; if (o_busy !== 1'b0 || dut.ptr !== 3'd0) begin failures++; $display("FAIL ar_after busy=%b ptr=%0d want busy=0 ptr=0", o_busy, dut.ptr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet();
        test_back_to_back();
        test_backpressure();
`ifdef OUTPUT_ALLOC_WDOG_EN
        test_wdog();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_output_allocator.md
Name: router_output_allocator

Overview:
- Per-output-port wormhole switch allocator for the mesh Router; one instance per output port (LOCAL/NORTH/SOUTH/EAST/WEST).
- Arbitrates between the input ports whose current flit targets this output, using round-robin priority.
- Locks the output to the winning input from the head flit until the tail flit, and gates every transfer on the downstream on/off flow-control signal.
- Drives the crossbar mux select and the per-input grant (dequeue) strobes.

Parameters:
- NUM_IN, 5, number of requesting input ports (equals NUM_OF_PORTS).
- SEL_W, $clog2(NUM_IN), width of the mux select.
- WDOG_CYCLES, 64, starvation limit used only when OUTPUT_ALLOC_WDOG_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  NUM_IN  input i presents a valid flit routed to this output.
- i_head  in  NUM_IN  flit at input i is a head or single-flit packet.
- i_tail  in  NUM_IN  flit at input i is a tail or single-flit packet.
- i_downstream_on  in  1  downstream on/off; 1 = a flit may be sent this cycle.
- o_grant  out  NUM_IN  one-hot; input i's flit is transferred this cycle.
- o_sel  out  SEL_W  crossbar select; index of the current/last owner.
- o_valid  out  1  a flit crosses to the output this cycle (OR of o_grant).
- o_busy  out  1  output is locked to a packet (LOCKED state).
- o_wdog_err  out  1  one-cycle pulse when a locked packet is forcibly released.

Behaviour:
- State: fsm {IDLE, LOCKED}, owner[SEL_W], ptr[SEL_W].
- Reset: fsm=IDLE, owner=0, ptr=0, watchdog count=0.
- Output values while reset is asserted: o_grant=0, o_valid=0, o_busy=0, o_wdog_err=0, o_sel=0.
- Reset asserted mid-packet drops the lock immediately (asynchronous).
- Timing: o_grant, o_valid and o_sel are combinational from the registered state and the current inputs (zero-cycle grant). State updates on the rising clk edge.

- IDLE:
  - Eligible inputs: e[i] = i_req[i] & i_head[i].
  - Winner: first set bit of e, scanning ptr, ptr+1, ... with wrap modulo NUM_IN.
  - Non-head requests are ignored in IDLE: no grant and no state change.
  - If any input is eligible and i_downstream_on=1: o_grant = onehot(winner) and o_sel = winner.
  - If that flit has i_tail=1 (single-flit packet): stay in IDLE, ptr <= (winner+1) mod NUM_IN.
  - Otherwise: fsm <= LOCKED, owner <= winner. ptr is unchanged.
  - If i_downstream_on=0: no grant and no state change. o_sel holds owner.
- LOCKED:
  - o_busy=1 and o_sel=owner.
  - o_grant[owner] = i_req[owner] & i_downstream_on. All other grant bits are 0.
  - Requests from other inputs, including head flits, are never granted.
  - On a granted flit with i_tail[owner]=1: fsm <= IDLE, ptr <= (owner+1) mod NUM_IN.
  - A head flit arriving from the owner while LOCKED is treated as a body flit. No error is flagged.
- Simultaneous events:
  - A tail grant and a new head request elsewhere in the same cycle: the new head is arbitrated on the next cycle. There is a guaranteed one-cycle bubble only between multi-flit packets.
  - Single-flit packets may be granted back-to-back, one per cycle, with the round-robin pointer advancing each time.
- Fairness: with all inputs continuously requesting, each input is granted one packet per NUM_IN packets.
- Wrap: ptr and the winner search wrap modulo NUM_IN. This also holds for non-power-of-two NUM_IN; ptr never holds a value of NUM_IN or above.

Optional Feature:
- Macro: OUTPUT_ALLOC_WDOG_EN.
- Defined:
  - In LOCKED, a counter increments on each cycle where i_req[owner]=0.
  - The counter clears on any grant and on entry to LOCKED. Downstream-off cycles do not count.
  - When the count reaches WDOG_CYCLES: fsm <= IDLE, ptr <= (owner+1) mod NUM_IN, and o_wdog_err pulses high for exactly one cycle.
- Undefined: no counter logic is built, o_wdog_err is tied to 0, and LOCKED holds indefinitely.

Test Plan:
1. Single-flit packet at input 2 (req/head/tail=1, on=1), from reset: o_grant=5'b00100 in the same cycle, o_sel=2, fsm stays IDLE, ptr becomes 3.
2. 3-flit packet on input 1 while input 3 holds a head flit: grants go to input 1 for 3 consecutive cycles; input 3 is granted on the 5th cycle (one bubble); ptr=2 after input 1's tail.
3. Inputs 0-4 all sending continuous single-flit packets, ptr=0: grant order 0,1,2,3,4,0, one per cycle.
4. LOCKED on input 4, i_downstream_on=0 for 10 cycles: o_grant=0 and o_busy=1 throughout; grants resume the cycle on returns to 1; with the macro defined, o_wdog_err stays 0.
5. Macro defined, WDOG_CYCLES=8: input 0 sends a head then drops req for 8 cycles. o_wdog_err pulses exactly once, fsm=IDLE, ptr=1, and input 2's pending head is granted the next cycle.
6. Reset asserted while LOCKED mid-packet (asynchronous, between edges): o_busy and o_grant drop immediately; after release, fsm=IDLE and ptr=0.
